piso_serializer: RTL and testbench



---
 rtl/piso_pkg.sv | 18 +
 rtl/piso_serializer.sv | 109 ++++++++++
 tb/tb_piso_serializer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out serializer.
package piso_pkg;

    // Serializer control state: idle, or a frame currently on sout.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit-counter width for a given word width (bits remaining, 0..width-1).
    function automatic int unsigned piso_cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    // Counter width for the default 4-bit word.
    localparam int unsigned PISO_CNT_W_DEFAULT = piso_cnt_width(4);

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with a one-word holding buffer so that
// back-to-back words stream on sout with no idle bit between them.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done
);

    localparam int unsigned    CW       = piso_cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             accept;

    assign load_ready = !hold_full_q;
    assign accept     = load_valid && !hold_full_q;

    // Shift sreg one place toward the output end, zero-filling the far end.
    always_comb begin
        sreg_shifted = '0;
        if (MSB_FIRST) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load, shift, hand-off from hold, or bypass on last bit.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = din;
                    cnt_d   = CNT_LAST;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Shifting on the final bit of an idle-bound frame leaves sreg
                // all-zero, so sout rests at 0 while idle.
                sreg_d = sreg_shifted;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (accept) begin
                        hold_d      = din;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sreg_d      = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = CNT_LAST;
                end else if (accept) begin
                    sreg_d = din;
                    cnt_d  = CNT_LAST;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sout        = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sout_valid  = (state_q == SHIFT);
    assign frame_start = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign done        = (state_q == SHIFT) && (cnt_q == '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: one MSB-first 4-bit and one LSB-first
// 8-bit instance, each with its own stimulus, reference queue and monitor.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int unsigned W = (g == 0) ? 4 : 8;
        localparam bit          M = (g == 0);
        localparam logic [W-1:0] WORD_A = (W == 4) ? W'(4'b1011) : W'(8'hA5);
        localparam logic [W-1:0] WORD_B = (W == 4) ? W'(4'b0110) : W'(8'h3C);
        localparam logic [W-1:0] WORD_L = (W == 4) ? W'(4'b1101) : W'(8'hD2);

        logic         rst_n, load_valid, load_ready, sout, sout_valid, frame_start, done;
        logic [W-1:0] din;
        logic [W-1:0] sipo_q;
        logic         fin = 1'b0;
        // Expected serial stream: {bit, frame_start, done} per output cycle.
        logic [2:0]   exp_q[$];

        piso_serializer #(.WIDTH(W), .MSB_FIRST(M)) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_valid  (load_valid),
            .din         (din),
            .load_ready  (load_ready),
            .sout        (sout),
            .sout_valid  (sout_valid),
            .frame_start (frame_start),
            .done        (done)
        );

        // Receiving SIPO, shift direction matched to the serializer's bit order.
        always @(posedge clk) begin
            if (M) sipo_q <= {sipo_q[W-2:0], sout};
            else   sipo_q <= {sout, sipo_q[W-1:1]};
        end

        // Monitor: every cycle with sout_valid consumes one expected bit.
        initial forever begin
            logic [2:0] e;
            @(negedge clk);
            if (sout_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sout_valid", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("sout", sout, e[2]);
                    check("frame_start", frame_start, e[1]);
                    check("done", done, e[0]);
                end
            end else begin
                check("sout_valid_gap", sout_valid, (exp_q.size() != 0));
                check("idle_sout", sout, 1'b0);
                check("idle_markers", {frame_start, done}, 2'b00);
            end
        end

        // One input cycle. Ready is predicted from the bits still owed: once the
        // current bit is out, fewer than W pending means the buffer is free.
        task automatic cyc(input logic v, input logic [W-1:0] d);
            logic rdy;
            @(negedge clk);
            #1;
            rdy = (exp_q.size() < W);
            check("load_ready", load_ready, rdy);
            load_valid = v;
            din        = d;
            if (v && rdy) begin
                for (int unsigned i = 0; i < W; i++) begin
                    exp_q.push_back({(M ? d[W-1-i] : d[i]), (i == 0), (i == W - 1)});
                end
            end
        endtask

        task automatic idle(input int unsigned n);
            for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0);
        endtask

        initial begin
            rst_n      = 1'b1;
            load_valid = 1'b0;
            din        = '0;
            #1 rst_n = 1'b0;
            #1;
            check("reset_outputs", {sout, sout_valid, frame_start, done}, 4'b0000);
            check("reset_load_ready", load_ready, 1'b1);
            #11 rst_n = 1'b1;
            idle(2);

            // Single word.
            cyc(1'b1, WORD_A);
            idle(W + 2);

            // Back-to-back: second word offered two cycles later, lands in hold.
            cyc(1'b1, WORD_A);
            idle(1);
            cyc(1'b1, WORD_B);
            idle(2 * W + 2);

            // Bypass: second word offered exactly in the done cycle.
            cyc(1'b1, WORD_B);
            idle(W - 1);
            cyc(1'b1, WORD_A);
            idle(W + 2);

            // Loopback into a SIPO.
            cyc(1'b1, WORD_L);
            idle(W);
            @(posedge clk);
            #1;
            check("sipo_loopback", sipo_q, WORD_L);
            idle(2);

            // Asynchronous reset mid-frame with the hold buffer full.
            cyc(1'b1, WORD_A);
            cyc(1'b1, WORD_B);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("midframe_reset_outputs", {sout, sout_valid, frame_start, done}, 4'b0000);
            check("midframe_reset_ready", load_ready, 1'b1);
            exp_q.delete();
            load_valid = 1'b0;
            #1 rst_n = 1'b1;
            idle(3);

            // Randomized traffic.
            for (int unsigned i = 0; i < 400; i++) begin
                cyc(($urandom_range(0, 9) < 7), W'($urandom));
            end
            idle(2 * W + 2);
            fin = 1'b1;
        end
    end

    initial begin
        wait (cfg[0].fin && cfg[1].fin);
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
